// File: rtl/hhrb98_div_pkg.sv
// Shared types and constants for the TinyTapeout sequential 8/4 restoring divider.
// The status-view helper packs the remainder and the divide-by-zero flag.
package hhrb98_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITER = 8;
  localparam int CNT_W    = 3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

  localparam logic [7:0] UIO_OE_MASK = 8'hC0;

  localparam int START_BIT = 4;
  localparam int SEL_BIT   = 5;
  localparam int BUSY_BIT  = 6;
  localparam int DONE_BIT  = 7;

  function automatic logic [7:0] status_view(input logic dbz, input logic [3:0] rem);
    return {dbz, 3'b000, rem};
  endfunction

endpackage

// File: rtl/hhrb98_div_if.sv
// Bundles for the divider: the TinyTapeout pin set seen from a driver, and the
// single-step datapath link between the divider FSM and its shift/subtract cell.
interface hhrb98_div_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

interface hhrb98_step_if;
  logic [3:0] rem;
  logic       bit_in;
  logic [3:0] divisor;
  logic [3:0] rem_nxt;
  logic       q_bit;

  modport master (output rem, bit_in, divisor, input rem_nxt, q_bit);
  modport slave  (input rem, bit_in, divisor, output rem_nxt, q_bit);
endinterface

// File: rtl/hhrb98_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not go negative.
module div_step (
  hhrb98_step_if.slave s
);

  logic [4:0] trial_s;
  logic [4:0] diff_s;
  logic       ge_s;

  // Trial subtract is 5 bits wide; a kept difference is always below the divisor.
  always_comb begin
    trial_s = {s.rem, s.bit_in};
    diff_s  = trial_s - {1'b0, s.divisor};
    ge_s    = (trial_s >= {1'b0, s.divisor});
    if (ge_s) begin
      s.rem_nxt = diff_s[3:0];
    end else begin
      s.rem_nxt = trial_s[3:0];
    end
    s.q_bit = ge_s;
  end

endmodule

// File: rtl/tt_um_seq_divider_hhrb98.sv
// TinyTapeout slot top: start/busy/done FSM around a one-bit-per-clock restoring
// divider (8-bit dividend / 4-bit divisor), with a combinational result-view mux.
module tt_um_seq_divider_hhrb98
  import hhrb98_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       quo_q, quo_d;
  // Partial remainder bit 4 is always 0 after a step, so only 4 bits are kept.
  logic [3:0]       rem_q, rem_d;
  logic [3:0]       dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic             start_s;
  logic             sel_s;
  logic             unused_bits_s;

  assign start_s       = uio_in[START_BIT];
  assign sel_s         = uio_in[SEL_BIT];
  assign unused_bits_s = &{1'b0, uio_in[7:6]};

  hhrb98_step_if step_bus ();

  assign step_bus.rem     = rem_q;
  assign step_bus.bit_in  = quo_q[7];
  assign step_bus.divisor = dvs_q;

  div_step u_step (
    .s (step_bus)
  );

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      quo_q   <= 8'h00;
      rem_q   <= 4'h0;
      dvs_q   <= 4'h0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update; everything holds while the slot is disabled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start_s) begin
            quo_d = ui_in;
            dvs_d = uio_in[3:0];
            rem_d = 4'h0;
            dbz_d = 1'b0;
            cnt_d = {CNT_W{1'b0}};
            if (uio_in[3:0] == 4'h0) begin
              quo_d   = 8'hFF;
              dbz_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          rem_d = step_bus.rem_nxt;
          quo_d = {quo_q[6:0], step_bus.q_bit};
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output views: result mux on sel, status bits decoded from the state register.
  always_comb begin
    uio_out = 8'h00;
    if (sel_s) begin
      uo_out = status_view(dbz_q, rem_q);
    end else begin
      uo_out = quo_q;
    end
    uio_out[BUSY_BIT] = (state_q == RUN);
    uio_out[DONE_BIT] = (state_q == DONE);
    uio_oe            = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Scoreboard bench for the sequential divider: stimulus pushes a/b results from
// integer arithmetic, a monitor pops and compares both result views on each result.
module tb_tt_um_seq_divider_hhrb98;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hhrb98_div_if pins ();

  logic [3:0] div_v;
  logic       start_v;
  logic       sel_v;
  assign pins.uio_in = {2'b00, sel_v, start_v, div_v};

  tt_um_seq_divider_hhrb98 dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uio_in  (pins.uio_in),
    .uo_out  (pins.uo_out),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  wire busy = pins.uio_out[6];
  wire done = pins.uio_out[7];

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dbz = 1'b1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start high and take the next edge as the acceptance edge.
  task automatic launch(input int a, input int b);
    pins.ui_in = 8'(a);
    div_v      = 4'(b);
    start_v    = 1'b1;
    tick();
    exp_q.push_back(model(a, b));
  endtask

  // Edges after acceptance until done, bounded.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) busy_n++;
      if (busy && done) check("busy_and_done", 32'd1, 32'd0);
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input int a, input int b, input bit hold);
    int lat, bn, b0;
    launch(a, b);
    b0 = busy ? 1 : 0;
    if (!hold) start_v = 1'b0;
    wait_done(lat, bn);
    check("done_latency", 32'(lat), (b == 0) ? 32'd0 : 32'd8);
    check("busy_cycles", 32'(bn + b0), (b == 0) ? 32'd0 : 32'd8);
  endtask

  // Monitor: a result is a rising done, or done right after an accepted start.
  initial begin : monitor
    exp_t e;
    logic done_prev, acc_prev;
    sel_v = 1'b0;
    done_prev = 1'b0;
    acc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
        acc_prev  = 1'b0;
      end else begin
        if (done && (!done_prev || acc_prev)) begin
          if (exp_q.size() == 0) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("quotient_view", 32'(pins.uo_out), 32'(e.q));
            sel_v = 1'b1;
            #1;
            check("status_view", 32'(pins.uo_out), 32'({e.dbz, 3'b000, e.r}));
            sel_v = 1'b0;
          end
        end
        done_prev = done;
        acc_prev  = pins.ena && start_v && !busy;
      end
    end
  end

  initial begin : stimulus
    int lat, bn, pre;
    rst = 1'b1;
    pins.ena = 1'b1;
    pins.ui_in = 8'h00;
    div_v = 4'h0;
    start_v = 1'b0;
    tick(); tick();
    check("reset_uo_out", 32'(pins.uo_out), 32'h00);
    check("reset_uio_out", 32'(pins.uio_out), 32'h00);
    check("reset_uio_oe", 32'(pins.uio_oe), 32'hC0);
    rst = 1'b0;
    tick();

    // Disabled slot must not accept start.
    pins.ena = 1'b0;
    pins.ui_in = 8'd9; div_v = 4'd2; start_v = 1'b1;
    tick(); tick();
    check("ena_low_no_start", 32'(pins.uio_out), 32'h00);
    start_v = 1'b0;
    pins.ena = 1'b1;
    tick();

    run_op(225, 15, 1'b0);
    tick();
    run_op(200, 7, 1'b0);
    tick();

    // Held start: 255/1 then an immediate relaunch of 0/9 from DONE.
    run_op(255, 1, 1'b1);
    pins.ui_in = 8'd0; div_v = 4'd9;
    run_op(0, 9, 1'b0);
    tick();

    run_op(100, 0, 1'b0);
    tick();

    // Operand change and start pulse mid-RUN are ignored.
    launch(77, 5);
    start_v = 1'b0;
    tick(); tick();
    pins.ui_in = 8'd200; div_v = 4'd3; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    wait_done(lat, bn);
    check("ignored_start_latency", 32'(lat + 3), 32'd8);
    tick();

    // ena low for three cycles mid-RUN.
    launch(77, 5);
    start_v = 1'b0;
    tick(); tick();
    pins.ena = 1'b0;
    tick(); tick(); tick();
    check("stall_busy_held", 32'(busy), 32'd1);
    pins.ena = 1'b1;
    pre = 5;
    wait_done(lat, bn);
    check("stall_latency", 32'(lat + pre), 32'd11);
    tick();

    // Asynchronous reset during iteration 4.
    launch(180, 11);
    start_v = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_uo_out", 32'(pins.uo_out), 32'h00);
    check("async_rst_uio_out", 32'(pins.uio_out), 32'h00);
    check("async_rst_uio_oe", 32'(pins.uio_oe), 32'hC0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    run_op(50, 3, 1'b0);
    tick();

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick(); tick(); tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
